// File: rtl/seq_div_if.sv
// seq_div handshake bundle: request operands in, results and status out.
interface seq_div_if #(
  parameter int N = 16
);
  logic         start;
  logic         signed_op;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_div.sv
// Radix-2 restoring divider, one quotient bit per clock,
// signed/unsigned per op, defined divide-by-zero result.
module seq_div #(
  parameter int N = 16
) (
  input logic  clk,
  input logic  rst,
  seq_div_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t        state;
  logic [N:0]    rem;
  logic [N-1:0]  dvd;
  logic [N-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic          neg_q;
  logic          neg_r;
  logic          dbz;

  logic          sa;
  logic          sb;
  logic [N-1:0]  mag_a;
  logic [N-1:0]  mag_b;
  logic [N:0]    shifted;
  logic [N:0]    trial;

  assign sa      = bus.signed_op & bus.dividend[N-1];
  assign sb      = bus.signed_op & bus.divisor[N-1];
  assign mag_a   = sa ? -bus.dividend : bus.dividend;
  assign mag_b   = sb ? -bus.divisor : bus.divisor;
  assign shifted = {rem[N-1:0], dvd[N-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      rem             <= '0;
      dvd             <= '0;
      dvs             <= '0;
      cnt             <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      dbz             <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            rem      <= '0;
            cnt      <= CW'(N);
            // dbz keeps the raw dividend as the remainder
            if (bus.divisor == '0) begin
              dbz   <= 1'b1;
              dvd   <= bus.dividend;
              state <= FIX;
            end else begin
              dbz   <= 1'b0;
              dvd   <= mag_a;
              dvs   <= mag_b;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!trial[N]) begin
            rem <= trial;
            dvd <= {dvd[N-2:0], 1'b1};
          end else begin
            rem <= shifted;
            dvd <= {dvd[N-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          bus.busy        <= 1'b0;
          bus.done        <= 1'b1;
          bus.div_by_zero <= dbz;
          if (dbz) begin
            bus.quotient  <= '1;
            bus.remainder <= dvd;
          end else begin
            bus.quotient  <= neg_q ? -dvd : dvd;
            bus.remainder <= neg_r ? -rem[N-1:0]
                                   : rem[N-1:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div (N=16): results, latency,
// divide-by-zero, overflow, ignored start and async reset.
module tb_seq_div;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   overlap = 0;

  seq_div_if #(.N(N)) io ();

  seq_div #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(io.busy), 32'd0);
    chk({tag, "_done"}, 32'(io.done), 32'd0);
    chk({tag, "_q"}, 32'(io.quotient), 32'd0);
    chk({tag, "_r"}, 32'(io.remainder), 32'd0);
    chk({tag, "_dbz"}, 32'(io.div_by_zero), 32'd0);
  endtask

  // Issues one op from the current time; returns #1 after done edge.
  task automatic op(input string tag,
                    input logic sg,
                    input logic [N-1:0] a,
                    input logic [N-1:0] b,
                    input logic [N-1:0] eq,
                    input logic [N-1:0] er,
                    input logic ed,
                    input int lat,
                    input bit poke);
    int n;
    int busy_n;
    io.start     = 1'b1;
    io.signed_op = sg;
    io.dividend  = a;
    io.divisor   = b;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    n = 0;
    busy_n = io.busy ? 1 : 0;
    while (!io.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (io.busy) busy_n++;
      if (io.busy && io.done) overlap++;
      if (poke && n == 5) begin
        io.start     = 1'b1;
        io.signed_op = ~sg;
        io.dividend  = 16'h1234;
        io.divisor   = 16'h0005;
      end else if (poke && n == 6) begin
        io.start = 1'b0;
      end
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_busy"}, 32'(busy_n), 32'(lat));
    chk({tag, "_q"}, 32'(io.quotient), 32'(eq));
    chk({tag, "_r"}, 32'(io.remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(io.div_by_zero), 32'(ed));
  endtask

  initial begin
    int dn;
    io.start     = 1'b0;
    io.signed_op = 1'b0;
    io.dividend  = '0;
    io.divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    op("u100_7", 1'b0, 16'd100, 16'd7,
       16'd14, 16'd2, 1'b0, 17, 1'b0);
    op("s_m100_7", 1'b1, 16'hFF9C, 16'h0007,
       16'hFFF2, 16'hFFFE, 1'b0, 17, 1'b0);
    op("s100_m7", 1'b1, 16'h0064, 16'hFFF9,
       16'hFFF2, 16'h0002, 1'b0, 17, 1'b0);
    op("uffff_1", 1'b0, 16'hFFFF, 16'h0001,
       16'hFFFF, 16'h0000, 1'b0, 17, 1'b0);
    op("u_dbz", 1'b0, 16'd1234, 16'd0,
       16'hFFFF, 16'h04D2, 1'b1, 1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("dbz_hold_q", 32'(io.quotient), 32'hFFFF);
    chk("dbz_hold_f", 32'(io.div_by_zero), 32'd1);
    op("s_dbz", 1'b1, 16'd1234, 16'd0,
       16'hFFFF, 16'h04D2, 1'b1, 1, 1'b0);
    op("clr_dbz", 1'b0, 16'd100, 16'd7,
       16'd14, 16'd2, 1'b0, 17, 1'b0);
    op("s_ovf", 1'b1, 16'h8000, 16'hFFFF,
       16'h8000, 16'h0000, 1'b0, 17, 1'b0);
    op("u_8000", 1'b0, 16'h8000, 16'hFFFF,
       16'h0000, 16'h8000, 1'b0, 17, 1'b0);
    op("poke", 1'b0, 16'd1000, 16'd3,
       16'd333, 16'd1, 1'b0, 17, 1'b1);
    // start issued inside the done cycle of the previous op
    op("b2b", 1'b1, 16'hFFF9, 16'h0002,
       16'hFFFD, 16'hFFFF, 1'b0, 17, 1'b0);

    io.start     = 1'b1;
    io.signed_op = 1'b0;
    io.dividend  = 16'd100;
    io.divisor   = 16'd7;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    dn = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (io.done) dn++;
    end
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (io.done) dn++;
    end
    chk("rst_no_done", 32'(dn), 32'd0);
    op("after_rst", 1'b0, 16'hC350, 16'd300,
       16'd166, 16'd200, 1'b0, 17, 1'b0);

    chk("busy_done_overlap", 32'(overlap), 32'd0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
